// File: rtl/player_motion_ctrl_pkg.sv
// Shared encodings for the player motion controller: axis states, move
// directions, button and wall-hit bit positions.
package player_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } axis_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;

  localparam int HIT_RIGHT  = 0;
  localparam int HIT_LEFT   = 1;
  localparam int HIT_BOTTOM = 2;
  localparam int HIT_TOP    = 3;

  // Opposing buttons cancel; takes already-inverted (active-high) presses.
  function automatic dir_t dir_decode(input logic pos_pressed, input logic neg_pressed);
    if (pos_pressed && !neg_pressed) return DIR_POS;
    if (neg_pressed && !pos_pressed) return DIR_NEG;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/player_motion_ctrl_axis_mover.sv
// One motion axis: IDLE/MOVE FSM, hold-to-accelerate speed ramp, and
// edge clamping with per-wall hit pulses. Everything advances on game_en.
module axis_mover
  import player_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int LIMIT      = 610,
  parameter int INIT       = 50,
  parameter int MIN_STEP   = 1,
  parameter int MAX_STEP   = 8,
  parameter int RAMP_TICKS = 4,
  parameter int SPEED_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  dir_t               dir,
  output logic [COORD_W-1:0] pos,
  output logic [SPEED_W-1:0] speed,
  output logic               move_next,
  output logic               hit_pos,
  output logic               hit_neg
);

  localparam int CNT_W = $clog2(RAMP_TICKS + 1);
  localparam logic [SPEED_W-1:0] MIN_S = SPEED_W'(MIN_STEP);
  localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_STEP);
  localparam logic [COORD_W:0]   LIM_E = (COORD_W + 1)'(LIMIT);

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] s);
    return (s >= MAX_S) ? MAX_S : s + 1'b1;
  endfunction

  axis_state_t        state_q, state_d;
  dir_t               last_dir_q, last_dir_d;
  logic [COORD_W-1:0] pos_q, pos_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_pos_q, hit_pos_d;
  logic               hit_neg_q, hit_neg_d;
  logic               do_move;
  logic               clamped;
  logic [SPEED_W-1:0] step;
  logic [COORD_W:0]   step_e;
  logic [COORD_W:0]   sum_e;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    pos_d      = pos_q;
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    hit_pos_d  = 1'b0;
    hit_neg_d  = 1'b0;
    do_move    = 1'b0;
    clamped    = 1'b0;
    step       = MIN_S;
    step_e     = '0;
    sum_e      = '0;
    if (game_en) begin
      case (state_q)
        ST_IDLE: begin
          if (dir != DIR_NONE) begin
            state_d    = ST_MOVE;
            last_dir_d = dir;
            speed_d    = MIN_S;
            cnt_d      = CNT_W'(1);
            do_move    = 1'b1;
          end
        end
        default: begin
          if (dir == DIR_NONE) begin
            state_d = ST_IDLE;
            speed_d = MIN_S;
            cnt_d   = '0;
          end else if (dir == last_dir_q) begin
            step    = speed_q;
            do_move = 1'b1;
            if (cnt_q == CNT_W'(RAMP_TICKS - 1)) begin
              cnt_d   = '0;
              speed_d = sat_inc(speed_q);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            last_dir_d = dir;
            speed_d    = MIN_S;
            cnt_d      = CNT_W'(1);
            do_move    = 1'b1;
          end
        end
      endcase

      // One extra bit keeps pos+step from wrapping before the compare.
      step_e = (COORD_W + 1)'(step);
      sum_e  = {1'b0, pos_q} + step_e;
      if (do_move) begin
        if (dir == DIR_POS) begin
          if (sum_e > LIM_E) begin
            pos_d     = COORD_W'(LIMIT);
            hit_pos_d = 1'b1;
            clamped   = 1'b1;
          end else begin
            pos_d = sum_e[COORD_W-1:0];
          end
        end else begin
          if ({1'b0, pos_q} < step_e) begin
            pos_d     = '0;
            hit_neg_d = 1'b1;
            clamped   = 1'b1;
          end else begin
            pos_d = pos_q - COORD_W'(step);
          end
        end
      end
      if (clamped) begin
        speed_d = MIN_S;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_NONE;
      pos_q      <= COORD_W'(INIT);
      speed_q    <= MIN_S;
      cnt_q      <= '0;
      hit_pos_q  <= 1'b0;
      hit_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      pos_q      <= pos_d;
      speed_q    <= speed_d;
      cnt_q      <= cnt_d;
      hit_pos_q  <= hit_pos_d;
      hit_neg_q  <= hit_neg_d;
    end
  end

  assign pos       = pos_q;
  assign speed     = speed_q;
  assign move_next = (state_d == ST_MOVE);
  assign hit_pos   = hit_pos_q;
  assign hit_neg   = hit_neg_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Two-axis sprite motion controller: decodes active-low buttons into per-axis
// directions and packs the axis status into moving/wall_hit.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BOX_W      = 30,
  parameter int BOX_H      = 30,
  parameter int INIT_X     = 50,
  parameter int INIT_Y     = 225,
  parameter int MIN_STEP   = 1,
  parameter int MAX_STEP   = 8,
  parameter int RAMP_TICKS = 4,
  parameter int SPEED_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic [3:0]         buttons,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic               moving,
  output logic [3:0]         wall_hit,
  output logic [SPEED_W-1:0] speed_x,
  output logic [SPEED_W-1:0] speed_y
);

  localparam int MAX_XPOS = SCREEN_W - BOX_W;
  localparam int MAX_YPOS = SCREEN_H - BOX_H;

  logic [3:0] pressed;
  dir_t       dir_x, dir_y;
  logic       x_move_next, y_move_next;
  logic       x_hit_pos, x_hit_neg, y_hit_pos, y_hit_neg;
  logic       moving_q, moving_d;

  assign pressed = ~buttons;
  assign dir_x   = dir_decode(pressed[BTN_R], pressed[BTN_L]);
  assign dir_y   = dir_decode(pressed[BTN_D], pressed[BTN_U]);

  axis_mover #(
    .COORD_W(COORD_W), .LIMIT(MAX_XPOS), .INIT(INIT_X), .MIN_STEP(MIN_STEP),
    .MAX_STEP(MAX_STEP), .RAMP_TICKS(RAMP_TICKS), .SPEED_W(SPEED_W)
  ) u_axis_x (
    .clk(clk), .rst(rst), .game_en(game_en), .dir(dir_x),
    .pos(box_x), .speed(speed_x), .move_next(x_move_next),
    .hit_pos(x_hit_pos), .hit_neg(x_hit_neg)
  );

  axis_mover #(
    .COORD_W(COORD_W), .LIMIT(MAX_YPOS), .INIT(INIT_Y), .MIN_STEP(MIN_STEP),
    .MAX_STEP(MAX_STEP), .RAMP_TICKS(RAMP_TICKS), .SPEED_W(SPEED_W)
  ) u_axis_y (
    .clk(clk), .rst(rst), .game_en(game_en), .dir(dir_y),
    .pos(box_y), .speed(speed_y), .move_next(y_move_next),
    .hit_pos(y_hit_pos), .hit_neg(y_hit_neg)
  );

  // Tracks the axis state registers so it only changes on a game tick.
  always_comb begin
    moving_d = moving_q;
    if (game_en) moving_d = x_move_next | y_move_next;
  end

  always_ff @(posedge clk) begin
    if (rst) moving_q <= 1'b0;
    else     moving_q <= moving_d;
  end

  assign moving = moving_q;

  always_comb begin
    wall_hit             = '0;
    wall_hit[HIT_RIGHT]  = x_hit_pos;
    wall_hit[HIT_LEFT]   = x_hit_neg;
    wall_hit[HIT_BOTTOM] = y_hit_pos;
    wall_hit[HIT_TOP]    = y_hit_neg;
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed-vector bench for player_motion_ctrl with hand-computed trajectories.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_en;
  logic [3:0] buttons;
  logic [9:0] box_x, box_y;
  logic       moving;
  logic [3:0] wall_hit;
  logic [3:0] speed_x, speed_y;

  int n_cmp = 0;
  int n_bad = 0;

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .game_en(game_en), .buttons(buttons),
    .box_x(box_x), .box_y(box_y), .moving(moving), .wall_hit(wall_hit),
    .speed_x(speed_x), .speed_y(speed_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One game tick; outputs are stable for checking when this returns.
  task automatic tick();
    @(negedge clk);
    game_en = 1'b1;
    @(negedge clk);
    game_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int exp_x2 [12] = '{51, 52, 53, 54, 56, 58, 60, 62, 65, 68, 71, 74};
  logic [3:0] hit_or;

  initial begin
    rst     = 1'b1;
    game_en = 1'b0;
    buttons = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      game_en = ~game_en;
    end
    @(negedge clk);
    game_en = 1'b0;
    buttons = 4'b1111;
    rst     = 1'b0;
    chk("rst_x", box_x, 50);
    chk("rst_y", box_y, 225);
    chk("rst_sx", speed_x, 1);
    chk("rst_sy", speed_y, 1);
    chk("rst_hit", wall_hit, 0);
    chk("rst_moving", moving, 0);

    // Hold right: ramp 1,2,3,4 every four ticks
    buttons = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("ramp_x%0d", i + 1), box_x, exp_x2[i]);
    end
    chk("ramp_sx", speed_x, 4);
    chk("ramp_moving", moving, 1);

    // Reset mid-ramp
    tick();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_x", box_x, 50);
    chk("midrst_sx", speed_x, 1);
    chk("midrst_moving", moving, 0);
    rst = 1'b0;
    buttons = 4'b1111;

    // Reversal then both pressed
    buttons = 4'b1110;
    ticks(6);
    chk("rev_pre_x", box_x, 58);
    chk("rev_pre_sx", speed_x, 2);
    buttons = 4'b1101;
    tick();
    chk("rev_x", box_x, 57);
    chk("rev_sx", speed_x, 1);
    buttons = 4'b1100;
    tick();
    chk("both_x", box_x, 57);
    chk("both_sx", speed_x, 1);
    chk("both_moving", moving, 0);

    // Right wall: three taps put x at 53, then 83 held ticks reach 605 at speed 8
    buttons = 4'b1111;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      buttons = 4'b1110;
      tick();
      buttons = 4'b1111;
      tick();
    end
    chk("tap_x", box_x, 53);
    buttons = 4'b1110;
    ticks(83);
    chk("pre_wall_x", box_x, 605);
    chk("pre_wall_sx", speed_x, 8);
    chk("pre_wall_hit", wall_hit, 0);
    tick();
    chk("rwall_x", box_x, 610);
    chk("rwall_hit", wall_hit, 4'b0001);
    chk("rwall_sx", speed_x, 1);
    @(negedge clk);
    chk("rwall_pulse_end", wall_hit, 0);
    tick();
    chk("rwall2_x", box_x, 610);
    chk("rwall2_hit", wall_hit, 4'b0001);
    chk("rwall2_moving", moving, 1);

    // Left wall: lands on 0 exactly at tick 18, clamps at tick 19
    buttons = 4'b1111;
    do_reset();
    buttons = 4'b1101;
    ticks(18);
    chk("lwall_pre_x", box_x, 0);
    chk("lwall_pre_hit", wall_hit, 0);
    tick();
    chk("lwall_x", box_x, 0);
    chk("lwall_hit", wall_hit, 4'b0010);
    chk("lwall_sx", speed_x, 1);

    // Top wall: y=1 after 42 ticks, clamp on 43rd
    buttons = 4'b1111;
    do_reset();
    buttons = 4'b0111;
    ticks(42);
    chk("twall_pre_y", box_y, 1);
    tick();
    chk("twall_y", box_y, 0);
    chk("twall_hit", wall_hit, 4'b1000);

    // Bottom wall: y=449 after 42 ticks, clamp to 450 on 43rd
    buttons = 4'b1111;
    do_reset();
    buttons = 4'b1011;
    ticks(42);
    chk("bwall_pre_y", box_y, 449);
    chk("bwall_pre_sy", speed_y, 8);
    tick();
    chk("bwall_y", box_y, 450);
    chk("bwall_hit", wall_hit, 4'b0100);
    chk("bwall_sy", speed_y, 1);

    // Diagonal up+left
    buttons = 4'b1111;
    do_reset();
    buttons = 4'b0101;
    ticks(3);
    chk("diag_x", box_x, 47);
    chk("diag_y", box_y, 222);
    chk("diag_moving", moving, 1);
    buttons = 4'b1111;
    tick();
    chk("diag_rel_moving", moving, 0);
    chk("diag_rel_x", box_x, 47);

    // game_en held low: nothing moves
    do_reset();
    buttons = 4'b1110;
    hit_or  = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hit_or = hit_or | wall_hit;
    end
    chk("noen_x", box_x, 50);
    chk("noen_hit", hit_or, 0);
    chk("noen_moving", moving, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
